mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 16, address width of both requester ports and the memory port.
REQ-002 SHALL have parameter WIDTH, default 8, data width of both requester ports and the memory port.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_req, b_req  input  1  access request from requester A (CPU) and requester B (loader/DMA).
REQ-006 SHALL have ports a_we, b_we  input  1  1 = write, 0 = read, for the pending request.
REQ-007 SHALL have ports a_addr, b_addr  input  WIDTH_ADDR  access address.
REQ-008 SHALL have ports a_wdata, b_wdata  input  WIDTH  write data.
REQ-009 SHALL have ports a_ack, b_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports a_rdata, b_rdata  output  WIDTH  read data, valid from the ack cycle until that port's next read completes.
REQ-011 SHALL have port mem_addr  output  WIDTH_ADDR  memory address.
REQ-012 SHALL have port mem_bus_dir  output  1  0 = main->mem, 1 = mem->main.
REQ-013 SHALL have port mem_load_main  output  1  active-low memory write qualifier; memory writes only when mem_load_main=0 and mem_bus_dir=0.
REQ-014 SHALL have port mem_assert_main  output  1  0 = memory drives the main bus.
REQ-015 SHALL have port mem_wdata  output  WIDTH  data to memory.
REQ-016 SHALL have port mem_rdata  input  WIDTH  memory read value.
REQ-017 SHALL have port grant  output  2  one-hot owner (bit0 = A, bit1 = B), 00 when idle.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and DONE; IDLE->ACCESS when any req=1 at the rising edge; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-019 SHALL, on IDLE->ACCESS, register the winner's we, addr and wdata; every mem_* output is driven from registers (no combinational path from requester inputs).
REQ-020 SHALL arbitrate round-robin: if only one req=1, grant it; if both, grant the port not served last; the last-served pointer updates on each grant.
REQ-021 SHALL hold grant at the winner's bit through ACCESS and DONE, and 00 in IDLE.
REQ-022 SHALL, in ACCESS for a write: mem_bus_dir=0, mem_load_main=0, mem_assert_main=1; the memory commits the write on the falling clock edge within ACCESS.
REQ-023 SHALL, in ACCESS for a read: mem_bus_dir=1, mem_load_main=1, mem_assert_main=0.
REQ-024 SHALL, in IDLE and DONE: mem_bus_dir=1, mem_load_main=1, mem_assert_main=1 (no write, memory not driving main).
REQ-025 SHALL, on a read, capture mem_rdata into the granted port's rdata register at the rising edge ending ACCESS; the other port's rdata is unchanged.
REQ-026 SHALL assert the granted port's ack for exactly the DONE cycle; the non-granted port's ack stays 0.
REQ-027 SHALL require a requester to hold req, we, addr and wdata stable until its ack and to drop req on the edge ending the ack cycle; a req still 1 in the following IDLE is a new request.
REQ-028 SHALL give a latency of 2 cycles from the IDLE-cycle req sample to ack, i.e. 3 cycles per transaction and one access per 3 cycles under continuous load.
REQ-029 SHALL ignore req changes on either port during ACCESS and DONE; a req arriving then is served no earlier than the next IDLE.
REQ-030 SHALL make a_ack and b_ack mutually exclusive, and make grant never 11.

Reset
REQ-031 SHALL, while reset=1 and asynchronously, force: state IDLE, grant=00, a_ack=b_ack=0, a_rdata=b_rdata=0, mem_addr=0, mem_wdata=0, mem_bus_dir=1, mem_load_main=1, mem_assert_main=1.
REQ-032 SHALL set the last-served pointer to B on reset, so A wins the first simultaneous request.
REQ-033 SHALL abort any in-flight transaction when reset asserts mid-ACCESS or mid-DONE: no ack is issued and the write qualifier is deasserted immediately.

Verification
REQ-034 SHALL cover A write: a_we=1, a_addr=0x1234, a_wdata=0xA5 -> grant=01, mem_load_main=0 and mem_bus_dir=0 for one cycle, a_ack 2 cycles after the req sample.
REQ-035 SHALL cover B read after that write: b_addr=0x1234 -> mem_assert_main=0 in ACCESS, b_ack pulse with b_rdata=0xA5, a_rdata unchanged.
REQ-036 SHALL cover simultaneous a_req and b_req after reset, held continuously -> grant order A, B, A, B, with acks 3 cycles apart.
REQ-037 SHALL cover reset asserted during a write ACCESS -> mem_load_main=1 immediately, no ack, grant=00, and the next transaction is normal.
REQ-038 SHALL cover b_req raised during A's ACCESS -> ignored until IDLE, then granted with ack 2 cycles later.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port seen by mem_arbiter.
// The arbiter takes the master view; requesters and memory take the slave view.
interface mem_arbiter_if #(
   parameter int WIDTH_ADDR = 16,
   parameter int WIDTH      = 8
);
   logic                  a_req, b_req;
   logic                  a_we, b_we;
   logic [WIDTH_ADDR-1:0] a_addr, b_addr;
   logic [WIDTH-1:0]      a_wdata, b_wdata;
   logic                  a_ack, b_ack;
   logic [WIDTH-1:0]      a_rdata, b_rdata;
   logic [WIDTH_ADDR-1:0] mem_addr;
   logic                  mem_bus_dir;
   logic                  mem_load_main;
   logic                  mem_assert_main;
   logic [WIDTH-1:0]      mem_wdata;
   logic [WIDTH-1:0]      mem_rdata;
   logic [1:0]            grant;

   modport master (
      input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
      output a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_bus_dir, mem_load_main,
             mem_assert_main, mem_wdata, grant
   );

   modport slave (
      output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
      input  a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_bus_dir, mem_load_main,
             mem_assert_main, mem_wdata, grant
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single memory; one access per 3 cycles
// (IDLE sample, ACCESS, DONE ack). All memory controls come straight from flops.
module mem_arbiter #(
   parameter int WIDTH_ADDR = 16,
   parameter int WIDTH      = 8
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [1:0]            ack_q, ack_d;
   logic                  last_b_q, last_b_d;
   logic                  we_q, we_d;
   logic [WIDTH_ADDR-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [WIDTH-1:0]      a_rdata_q, a_rdata_d;
   logic [WIDTH-1:0]      b_rdata_q, b_rdata_d;
   logic                  dir_q, dir_d;
   logic                  load_q, load_d;
   logic                  assert_q, assert_d;
   logic                  win_b;

   // B wins when alone, or when both ask and A was served last.
   assign win_b = bus.b_req & (~bus.a_req | ~last_b_q);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ack_d     = 2'b00;
      last_b_d  = last_b_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      dir_d     = 1'b1;
      load_d    = 1'b1;
      assert_d  = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               state_d  = ACCESS;
               grant_d  = win_b ? 2'b10 : 2'b01;
               last_b_d = win_b;
               we_d     = win_b ? bus.b_we    : bus.a_we;
               addr_d   = win_b ? bus.b_addr  : bus.a_addr;
               wdata_d  = win_b ? bus.b_wdata : bus.a_wdata;
               // ACCESS-cycle bus controls are staged here so they leave a flop.
               dir_d    = ~we_d;
               load_d   = ~we_d;
               assert_d = we_d;
            end
         end
         ACCESS: begin
            state_d = DONE;
            ack_d   = grant_q;
            if (!we_q) begin
               if (grant_q[1]) b_rdata_d = bus.mem_rdata;
               else            a_rdata_d = bus.mem_rdata;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         ack_q     <= 2'b00;
         last_b_q  <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         dir_q     <= 1'b1;
         load_q    <= 1'b1;
         assert_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         last_b_q  <= last_b_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         dir_q     <= dir_d;
         load_q    <= load_d;
         assert_q  <= assert_d;
      end
   end

   assign bus.grant           = grant_q;
   assign bus.a_ack           = ack_q[0];
   assign bus.b_ack           = ack_q[1];
   assign bus.a_rdata         = a_rdata_q;
   assign bus.b_rdata         = b_rdata_q;
   assign bus.mem_addr        = addr_q;
   assign bus.mem_wdata       = wdata_q;
   assign bus.mem_bus_dir     = dir_q;
   assign bus.mem_load_main   = load_q;
   assign bus.mem_assert_main = assert_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte memory model that commits
// writes on the falling edge and drives read data only while enabled.
module tb_mem_arbiter;
   logic clk;
   logic reset;
   logic tb_clr;
   int   n_err;
   int   n_chk;
   logic [7:0] mem [256];

   mem_arbiter_if #(.WIDTH_ADDR(16), .WIDTH(8)) bus ();

   mem_arbiter #(.WIDTH_ADDR(16), .WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (!bus.mem_load_main && !bus.mem_bus_dir) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = bus.mem_assert_main ? 8'hFF : mem[bus.mem_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_err = 0;
      n_chk = 0;
      reset = 1'b1;
      tb_clr = 1'b1;
      bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
      bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
      repeat (2) @(negedge clk);
      tb_clr = 1'b0;
      chk("rst_grant", bus.grant, 2'b00);
      chk("rst_a_ack", bus.a_ack, 0);
      chk("rst_b_ack", bus.b_ack, 0);
      chk("rst_a_rdata", bus.a_rdata, 0);
      chk("rst_b_rdata", bus.b_rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_dir", bus.mem_bus_dir, 1);
      chk("rst_load", bus.mem_load_main, 1);
      chk("rst_assert", bus.mem_assert_main, 1);
      tick;
      reset = 1'b0;

      // A write 0xA5 to 0x1234
      tick;
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h1234; bus.a_wdata = 8'hA5;
      @(negedge clk);
      chk("aw_idle_grant", bus.grant, 2'b00);
      @(negedge clk);
      chk("aw_acc_grant", bus.grant, 2'b01);
      chk("aw_acc_load", bus.mem_load_main, 0);
      chk("aw_acc_dir", bus.mem_bus_dir, 0);
      chk("aw_acc_assert", bus.mem_assert_main, 1);
      chk("aw_acc_addr", bus.mem_addr, 16'h1234);
      chk("aw_acc_ack", bus.a_ack, 0);
      @(negedge clk);
      chk("aw_done_ack", bus.a_ack, 1);
      chk("aw_done_back", bus.b_ack, 0);
      chk("aw_done_load", bus.mem_load_main, 1);
      chk("aw_done_dir", bus.mem_bus_dir, 1);
      chk("aw_done_grant", bus.grant, 2'b01);
      @(posedge clk); #1;
      bus.a_req = 0;
      @(negedge clk);
      chk("aw_post_ack", bus.a_ack, 0);
      chk("aw_post_grant", bus.grant, 2'b00);
      chk("aw_mem", mem[8'h34], 8'hA5);

      // B read of 0x1234
      tick;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      chk("br_acc_grant", bus.grant, 2'b10);
      chk("br_acc_assert", bus.mem_assert_main, 0);
      chk("br_acc_dir", bus.mem_bus_dir, 1);
      chk("br_acc_load", bus.mem_load_main, 1);
      @(negedge clk);
      chk("br_done_back", bus.b_ack, 1);
      chk("br_done_aack", bus.a_ack, 0);
      chk("br_done_rdata", bus.b_rdata, 8'hA5);
      chk("br_a_rdata", bus.a_rdata, 8'h00);
      chk("br_done_assert", bus.mem_assert_main, 1);
      @(posedge clk); #1;
      bus.b_req = 0;

      // simultaneous requests after reset, held for four transactions
      reset = 1'b1;
      tick;
      reset = 1'b0;
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h1234;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h1234;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_idle_grant", t), bus.grant, 2'b00);
         @(negedge clk);
         chk($sformatf("rr%0d_grant", t), bus.grant, (t % 2 == 0) ? 2'b01 : 2'b10);
         @(negedge clk);
         chk($sformatf("rr%0d_a_ack", t), bus.a_ack, (t % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_b_ack", t), bus.b_ack, (t % 2 == 0) ? 0 : 1);
         if (t == 0) chk("rr_a_rdata", bus.a_rdata, 8'hA5);
      end
      @(posedge clk); #1;
      bus.a_req = 0; bus.b_req = 0;

      // reset in the middle of a write ACCESS
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0020; bus.a_wdata = 8'h5A;
      @(negedge clk);
      @(posedge clk); #2;
      chk("rw_acc_load", bus.mem_load_main, 0);
      reset = 1'b1;
      #1;
      chk("rw_rst_load", bus.mem_load_main, 1);
      chk("rw_rst_dir", bus.mem_bus_dir, 1);
      chk("rw_rst_grant", bus.grant, 2'b00);
      chk("rw_rst_ack", bus.a_ack, 0);
      chk("rw_rst_addr", bus.mem_addr, 0);
      bus.a_req = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rw_post_ack", bus.a_ack, 0);
      chk("rw_post_grant", bus.grant, 2'b00);
      chk("rw_mem_untouched", mem[8'h20], 8'h00);
      @(negedge clk);
      chk("rw_post2_ack", bus.a_ack, 0);
      chk("rw_a_rdata", bus.a_rdata, 8'h00);

      // next transaction is normal: B writes 0x77 to 0x0020
      tick;
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0020; bus.b_wdata = 8'h77;
      @(negedge clk);
      @(negedge clk);
      chk("bw_acc_grant", bus.grant, 2'b10);
      chk("bw_acc_load", bus.mem_load_main, 0);
      @(negedge clk);
      chk("bw_done_ack", bus.b_ack, 1);
      @(posedge clk); #1;
      bus.b_req = 0;
      @(negedge clk);
      chk("bw_mem", mem[8'h20], 8'h77);
      chk("bw_post_grant", bus.grant, 2'b00);

      // b_req raised during A's ACCESS is held off until the next IDLE
      tick;
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h1234;
      @(posedge clk); #1;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0020;
      @(negedge clk);
      chk("late_acc_grant", bus.grant, 2'b01);
      @(negedge clk);
      chk("late_a_ack", bus.a_ack, 1);
      chk("late_b_ack0", bus.b_ack, 0);
      chk("late_done_grant", bus.grant, 2'b01);
      chk("late_a_rdata", bus.a_rdata, 8'hA5);
      @(posedge clk); #1;
      bus.a_req = 0;
      @(negedge clk);
      chk("late_idle_grant", bus.grant, 2'b00);
      chk("late_idle_back", bus.b_ack, 0);
      @(negedge clk);
      chk("late_b_grant", bus.grant, 2'b10);
      @(negedge clk);
      chk("late_b_ack", bus.b_ack, 1);
      chk("late_b_aack", bus.a_ack, 0);
      chk("late_b_rdata", bus.b_rdata, 8'h77);
      @(posedge clk); #1;
      bus.b_req = 0;
      @(negedge clk);
      chk("late_end_grant", bus.grant, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
